instr_fetch_unit: RTL and testbench

Instruction fetch stage of the multicycle processor. Owns the program counter, issues one request per instruction to instruction memory, latches the returned 16-bit word into an instruction register, and hands it to the decode stage with a valid/ready handshake. Branches and jumps from the execute stage redirect the PC and flush any fetched-but-unconsumed instruction.

---
 rtl/instr_fetch_unit_pkg.sv | 18 +
 rtl/instr_fetch_unit_if.sv | 36 +++
 rtl/instr_fetch_unit_adder_16.sv | 13 +
 rtl/instr_fetch_unit.sv | 119 +++++++++++
 tb/tb_instr_fetch_unit.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-stage types and defaults.
// State enum, bus widths, reset PC, PC step and timeout.
package fetch_pkg;

  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 16;

  localparam logic [ADDR_W-1:0] RESET_PC_DEF = 16'd0;
  localparam logic [ADDR_W-1:0] PC_STEP_DEF  = 16'd16;
  localparam logic [7:0]        TIMEOUT_DEF  = 8'd255;

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    ERR
  } state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: imem request/ack, decode valid/ready, redirect, error.
// master = fetch unit side, slave = memory/decode/execute side.
interface instr_fetch_unit_if;
  import fetch_pkg::*;

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_ready;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               fetch_err;

  modport master (
    output imem_req, imem_addr,
    output instr_valid, instr, instr_pc,
    output fetch_err,
    input  imem_ack, imem_rdata,
    input  instr_ready,
    input  redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr,
    input  instr_valid, instr, instr_pc,
    input  fetch_err,
    output imem_ack, imem_rdata,
    output instr_ready,
    output redirect, redirect_pc
  );

endinterface

// File: rtl/instr_fetch_unit_adder_16.sv
// 16-bit ripple adder with carry in/out.
// Ports: a, b, cin in; sum, cout out.
module adder_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {16'b0, cin};

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, imem request, instruction register.
// Ports: clk, rst (async, active-high), bus (fetch master view).
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [ADDR_W-1:0] PC_STEP  = PC_STEP_DEF,
  parameter logic [7:0]        TIMEOUT  = TIMEOUT_DEF
) (
  input logic                clk,
  input logic                rst,
  instr_fetch_unit_if.master bus
);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
  logic               err_q, err_d;
  logic [7:0]         wait_q, wait_d;

  logic [ADDR_W-1:0]  pc_inc;
  logic               unused_cout;
  logic [7:0]         wait_inc;

  adder_16 u_pc_add (
    .a    (pc_q),
    .b    (PC_STEP),
    .cin  (1'b0),
    .sum  (pc_inc),
    .cout (unused_cout)
  );

  assign wait_inc = wait_q + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      err_q      <= 1'b0;
      wait_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      err_q      <= err_d;
      wait_q     <= wait_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    err_d      = err_q;
    wait_d     = wait_q;
    unique case (state_q)
      FETCH: begin
        // Redirect beats a same-cycle ack: the returned word is stale.
        if (bus.redirect) begin
          pc_d   = bus.redirect_pc;
          wait_d = '0;
        end else if (bus.imem_ack) begin
          instr_d    = bus.imem_rdata;
          instr_pc_d = pc_q;
          pc_d       = pc_inc;
          state_d    = HOLD;
          wait_d     = '0;
        end else begin
          wait_d = wait_inc;
          if (wait_inc == TIMEOUT) begin
            err_d   = 1'b1;
            state_d = ERR;
          end
        end
      end
      HOLD: begin
        if (bus.redirect) begin
          pc_d    = bus.redirect_pc;
          state_d = FETCH;
          wait_d  = '0;
        end else if (bus.instr_ready) begin
          state_d = FETCH;
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  logic req_o;
  logic valid_o;

  always_comb begin
    req_o   = 1'b0;
    valid_o = 1'b0;
    unique case (state_q)
      FETCH:   req_o   = 1'b1;
      HOLD:    valid_o = 1'b1;
      default: ;
    endcase
  end

  assign bus.imem_req    = req_o;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = valid_o;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.fetch_err   = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit.
// Linear step sequence with hand-computed expectations.
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  instr_fetch_unit_if bus ();

  instr_fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst             = 1'b1;
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = 16'h0;
    bus.instr_ready = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 16'h0;

    #3;
    chk("rst_instr", bus.instr, 16'h0000);
    chk("rst_instr_pc", bus.instr_pc, 16'h0000);
    chk("rst_valid", {15'b0, bus.instr_valid}, 16'h0);
    chk("rst_err", {15'b0, bus.fetch_err}, 16'h0);
    chk("rst_addr", bus.imem_addr, 16'h0000);
    #9;
    rst = 1'b0;
    chk("rel_req", {15'b0, bus.imem_req}, 16'h1);

    // Straight-line fetch, same-cycle ack, decode always ready.
    bus.instr_ready = 1'b1;
    bus.imem_ack    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("sl_addr%0d", i), bus.imem_addr, 16'(i * 16));
      chk($sformatf("sl_req%0d", i), {15'b0, bus.imem_req}, 16'h1);
      chk($sformatf("sl_nv%0d", i), {15'b0, bus.instr_valid}, 16'h0);
      bus.imem_rdata = 16'h1000 + 16'(i);
      tick();
      chk($sformatf("sl_v%0d", i), {15'b0, bus.instr_valid}, 16'h1);
      chk($sformatf("sl_nreq%0d", i), {15'b0, bus.imem_req}, 16'h0);
      chk($sformatf("sl_instr%0d", i), bus.instr, 16'h1000 + 16'(i));
      chk($sformatf("sl_ipc%0d", i), bus.instr_pc, 16'(i * 16));
      tick();
    end

    // Backpressure at PC 0x40.
    bus.instr_ready = 1'b0;
    bus.imem_rdata  = 16'h2222;
    chk("bp_addr", bus.imem_addr, 16'h0040);
    tick();
    bus.imem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bp_v%0d", i), {15'b0, bus.instr_valid}, 16'h1);
      chk($sformatf("bp_instr%0d", i), bus.instr, 16'h2222);
      chk($sformatf("bp_ipc%0d", i), bus.instr_pc, 16'h0040);
      chk($sformatf("bp_req%0d", i), {15'b0, bus.imem_req}, 16'h0);
    end
    bus.instr_ready = 1'b1;
    tick();
    chk("bp_res_req", {15'b0, bus.imem_req}, 16'h1);
    chk("bp_res_addr", bus.imem_addr, 16'h0050);
    chk("bp_res_nv", {15'b0, bus.instr_valid}, 16'h0);

    // Redirect with same-cycle ack in FETCH.
    bus.imem_ack    = 1'b1;
    bus.imem_rdata  = 16'h3333;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0100;
    tick();
    bus.redirect = 1'b0;
    chk("rf_nv", {15'b0, bus.instr_valid}, 16'h0);
    chk("rf_instr", bus.instr, 16'h2222);
    chk("rf_addr", bus.imem_addr, 16'h0100);
    chk("rf_req", {15'b0, bus.imem_req}, 16'h1);
    bus.imem_rdata = 16'h4444;
    tick();
    chk("rf_v", {15'b0, bus.instr_valid}, 16'h1);
    chk("rf_instr2", bus.instr, 16'h4444);
    chk("rf_ipc2", bus.instr_pc, 16'h0100);
    tick();
    chk("rf_addr2", bus.imem_addr, 16'h0110);

    // Redirect in HOLD with ready high.
    bus.imem_rdata = 16'h5555;
    tick();
    chk("rh_v", {15'b0, bus.instr_valid}, 16'h1);
    chk("rh_ipc", bus.instr_pc, 16'h0110);
    bus.imem_ack    = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0200;
    tick();
    bus.redirect = 1'b0;
    chk("rh_nv", {15'b0, bus.instr_valid}, 16'h0);
    chk("rh_addr", bus.imem_addr, 16'h0200);
    chk("rh_req", {15'b0, bus.imem_req}, 16'h1);

    // Wrap-around from 0xFFF0.
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'hFFF0;
    tick();
    bus.redirect = 1'b0;
    chk("wr_addr0", bus.imem_addr, 16'hFFF0);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 16'h6666;
    tick();
    bus.imem_ack = 1'b0;
    chk("wr_ipc", bus.instr_pc, 16'hFFF0);
    chk("wr_addr1", bus.imem_addr, 16'h0000);
    chk("wr_err", {15'b0, bus.fetch_err}, 16'h0);
    tick();
    chk("wr_req", {15'b0, bus.imem_req}, 16'h1);
    chk("wr_addr2", bus.imem_addr, 16'h0000);

    // Timeout: 255 ack-less FETCH cycles.
    for (int i = 0; i < 254; i++) tick();
    chk("to_pre_err", {15'b0, bus.fetch_err}, 16'h0);
    chk("to_pre_req", {15'b0, bus.imem_req}, 16'h1);
    tick();
    chk("to_err", {15'b0, bus.fetch_err}, 16'h1);
    chk("to_req", {15'b0, bus.imem_req}, 16'h0);
    chk("to_nv", {15'b0, bus.instr_valid}, 16'h0);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0300;
    bus.imem_ack    = 1'b1;
    tick();
    tick();
    bus.redirect = 1'b0;
    bus.imem_ack = 1'b0;
    chk("er_err", {15'b0, bus.fetch_err}, 16'h1);
    chk("er_req", {15'b0, bus.imem_req}, 16'h0);
    chk("er_addr", bus.imem_addr, 16'h0000);
    chk("er_nv", {15'b0, bus.instr_valid}, 16'h0);

    // Async reset mid-ERR.
    #2;
    rst = 1'b1;
    #1;
    chk("rr_err", {15'b0, bus.fetch_err}, 16'h0);
    chk("rr_instr", bus.instr, 16'h0000);
    chk("rr_ipc", bus.instr_pc, 16'h0000);
    chk("rr_req", {15'b0, bus.imem_req}, 16'h1);
    #2;
    rst            = 1'b0;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 16'h7777;
    chk("rr_addr", bus.imem_addr, 16'h0000);
    tick();
    chk("rr_v", {15'b0, bus.instr_valid}, 16'h1);
    chk("rr_instr2", bus.instr, 16'h7777);
    chk("rr_ipc2", bus.instr_pc, 16'h0000);
    chk("rr_addr2", bus.imem_addr, 16'h0010);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
